// File: rtl/snake_pkg.sv
// Shared encodings, grid geometry and start position for the snake engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int GRID_COLS = 64;
  localparam int GRID_ROWS = 48;
  localparam int CELL      = 10;
  localparam int CELL_OFS  = 5;
  localparam int N_SEG     = 4;

  localparam logic [5:0] START_COL = 6'd4;
  localparam logic [5:0] START_ROW = 6'd10;

  // UP<->DOWN and LEFT<->RIGHT differ only in the low bit.
  function automatic dir_t dir_rev(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  // Cell index to pixel centre; 63*10+5 = 635 fits in 10 bits.
  function automatic logic [9:0] cell_to_pix(input logic [5:0] c);
    return ({4'b0000, c} * 10'(CELL)) + 10'(CELL_OFS);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Free-running 0..DIV-1 counter with hold (en low) and clear; tick marks the last count.
module snake_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // Count while enabled, wrap on the tick, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game-state engine: 4 segments on a 64x48 grid, driving VGA segment centres.
//
// state   | meaning
// IDLE    | snake parked at start position, waiting for a btnC rising edge
// RUN     | one move per tick; pause holds the tick counter
// OVER    | wall hit; blackout toggles each tick, then back to IDLE
module snake_engine
  import snake_pkg::*;
#(
  parameter int TICK_DIV    = 10_000_000,
  parameter int WRAP        = 1,
  parameter int BLINK_COUNT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  input  logic       pause,
  output logic [9:0] xCoord1,
  output logic [9:0] xCoord2,
  output logic [9:0] xCoord3,
  output logic [9:0] xCoord4,
  output logic [9:0] yCoord1,
  output logic [9:0] yCoord2,
  output logic [9:0] yCoord3,
  output logic [9:0] yCoord4,
  output logic       blackout,
  output logic       game_over
);

  localparam int BW = $clog2(BLINK_COUNT + 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_COUNT - 1);

  logic [5:0] raw_in;
  logic [5:0] sync1_q, sync2_q;
  logic       btnc_prev_q;
  logic       up_s, dn_s, lf_s, rt_s, pause_s, start;

  state_t          state_q;
  dir_t            dir_q, pend_q, dir_d, req_dir;
  logic            req_vld;
  logic [BW-1:0]   blink_q;
  logic            blackout_q, game_over_q;

  logic [5:0] col_q [N_SEG];
  logic [5:0] row_q [N_SEG];
  logic [5:0] col_d [N_SEG];
  logic [5:0] row_d [N_SEG];
  logic [9:0] x_q   [N_SEG];
  logic [9:0] y_q   [N_SEG];

  logic       tick, tick_en, tick_clr;
  logic [5:0] head_col, head_row;
  logic       edge_hit, hit, do_move, load_start;

  assign raw_in  = {btnU, btnD, btnL, btnR, btnC, pause};
  assign up_s    = sync2_q[5];
  assign dn_s    = sync2_q[4];
  assign lf_s    = sync2_q[3];
  assign rt_s    = sync2_q[2];
  assign pause_s = sync2_q[0];
  assign start   = sync2_q[1] && !btnc_prev_q;

  // Two-flop synchronisers plus the btnC edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btnc_prev_q <= 1'b0;
    end else begin
      sync1_q     <= raw_in;
      sync2_q     <= sync1_q;
      btnc_prev_q <= sync2_q[1];
    end
  end

  // Counter is parked at 0 in IDLE so RUN always starts a full tick period.
  assign tick_en  = ((state_q == ST_RUN) && !pause_s) || (state_q == ST_OVER);
  assign tick_clr = (state_q == ST_IDLE);

  snake_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Highest-priority pressed direction button, U > D > L > R.
  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_RIGHT;
    if (up_s)      req_dir = DIR_UP;
    else if (dn_s) req_dir = DIR_DOWN;
    else if (lf_s) req_dir = DIR_LEFT;
    else if (rt_s) req_dir = DIR_RIGHT;
    else           req_vld = 1'b0;
  end

  // Pending becomes committed on every RUN tick, even one that hits a wall.
  assign dir_d = ((state_q == ST_RUN) && tick) ? pend_q : dir_q;

  // Candidate head cell for the pending direction, wrapped at the grid edges.
  always_comb begin
    head_col = col_q[0];
    head_row = row_q[0];
    edge_hit = 1'b0;
    case (pend_q)
      DIR_UP: begin
        if (row_q[0] == 6'd0) begin
          edge_hit = 1'b1;
          head_row = 6'(GRID_ROWS - 1);
        end else begin
          head_row = row_q[0] - 6'd1;
        end
      end
      DIR_DOWN: begin
        if (row_q[0] == 6'(GRID_ROWS - 1)) begin
          edge_hit = 1'b1;
          head_row = 6'd0;
        end else begin
          head_row = row_q[0] + 6'd1;
        end
      end
      DIR_LEFT: begin
        if (col_q[0] == 6'd0) begin
          edge_hit = 1'b1;
          head_col = 6'(GRID_COLS - 1);
        end else begin
          head_col = col_q[0] - 6'd1;
        end
      end
      default: begin
        if (col_q[0] == 6'(GRID_COLS - 1)) begin
          edge_hit = 1'b1;
          head_col = 6'd0;
        end else begin
          head_col = col_q[0] + 6'd1;
        end
      end
    endcase
  end

  assign hit        = edge_hit && (WRAP == 0);
  assign do_move    = (state_q == ST_RUN) && tick && !hit;
  assign load_start = (state_q == ST_OVER) && tick && (blink_q == LAST_BLINK);

  // Next segment cells: reload, shift-and-advance, or hold.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_start) begin
      for (int i = 0; i < N_SEG; i++) begin
        col_d[i] = START_COL - 6'(i);
        row_d[i] = START_ROW;
      end
    end else if (do_move) begin
      for (int i = N_SEG - 1; i > 0; i--) begin
        col_d[i] = col_q[i-1];
        row_d[i] = row_q[i-1];
      end
      col_d[0] = head_col;
      row_d[0] = head_row;
    end
  end

  // Segment cells and their registered pixel centres move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SEG; i++) begin
        col_q[i] <= START_COL - 6'(i);
        row_q[i] <= START_ROW;
        x_q[i]   <= cell_to_pix(START_COL - 6'(i));
        y_q[i]   <= cell_to_pix(START_ROW);
      end
    end else begin
      for (int i = 0; i < N_SEG; i++) begin
        col_q[i] <= col_d[i];
        row_q[i] <= row_d[i];
        x_q[i]   <= cell_to_pix(col_d[i]);
        y_q[i]   <= cell_to_pix(row_d[i]);
      end
    end
  end

  // Game FSM with direction latch and registered blackout/game_over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      blink_q     <= '0;
      blackout_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      if (load_start) begin
        dir_q  <= DIR_RIGHT;
        pend_q <= DIR_RIGHT;
      end else begin
        dir_q <= dir_d;
        // Reversal is judged against the direction in force after this edge.
        if (req_vld && (req_dir != dir_rev(dir_d))) pend_q <= req_dir;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (tick && hit) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
          end
        end
        ST_OVER: begin
          if (tick) begin
            if (blink_q == LAST_BLINK) begin
              state_q     <= ST_IDLE;
              blink_q     <= '0;
              blackout_q  <= 1'b0;
              game_over_q <= 1'b0;
            end else begin
              blink_q    <= blink_q + BW'(1);
              blackout_q <= ~blackout_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xCoord1   = x_q[0];
  assign xCoord2   = x_q[1];
  assign xCoord3   = x_q[2];
  assign xCoord4   = x_q[3];
  assign yCoord1   = y_q[0];
  assign yCoord2   = y_q[1];
  assign yCoord3   = y_q[2];
  assign yCoord4   = y_q[3];
  assign blackout  = blackout_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: wrapping and non-wrapping instances share stimulus,
// a grid-level model predicts every output each cycle, plus literal spot checks.
module tb_snake_engine;

  localparam int TD = 4;
  localparam int BC = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0, pause = 1'b0;

  logic [9:0] xw [2][4];
  logic [9:0] yw [2][4];
  logic       bo_w [2];
  logic       go_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snake_engine #(.TICK_DIV(TD), .WRAP(1), .BLINK_COUNT(BC)) u_wrap (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .btnC(btnC), .pause(pause),
    .xCoord1(xw[0][0]), .xCoord2(xw[0][1]), .xCoord3(xw[0][2]), .xCoord4(xw[0][3]),
    .yCoord1(yw[0][0]), .yCoord2(yw[0][1]), .yCoord3(yw[0][2]), .yCoord4(yw[0][3]),
    .blackout(bo_w[0]), .game_over(go_w[0])
  );

  snake_engine #(.TICK_DIV(TD), .WRAP(0), .BLINK_COUNT(BC)) u_nowrap (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .btnC(btnC), .pause(pause),
    .xCoord1(xw[1][0]), .xCoord2(xw[1][1]), .xCoord3(xw[1][2]), .xCoord4(xw[1][3]),
    .yCoord1(yw[1][0]), .yCoord2(yw[1][1]), .yCoord3(yw[1][2]), .yCoord4(yw[1][3]),
    .blackout(bo_w[1]), .game_over(go_w[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // play: 0 idle, 1 running, 2 game over. dirs: 0 up, 1 down, 2 left, 3 right.
  int m_st [2], m_cnt [2], m_blink [2], m_dir [2], m_pend [2];
  int m_col [2][4];
  int m_row [2][4];
  bit m_bo [2], m_go [2];
  bit [5:0] m_s1, m_s2;
  bit m_cprev;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic m_load(input int k);
    for (int i = 0; i < 4; i++) begin
      m_col[k][i] = 4 - i;
      m_row[k][i] = 10;
    end
    m_dir[k]  = 3;
    m_pend[k] = 3;
  endtask

  task automatic m_step(input int k, input bit wrapm);
    bit p, start, en, tick, vld, off;
    int r, dnext, nc, nr, dc, dr;
    p     = m_s2[0];
    start = m_s2[1] && !m_cprev;
    en    = (m_st[k] == 1 && !p) || m_st[k] == 2;
    tick  = en && (m_cnt[k] == TD - 1);
    dnext = (m_st[k] == 1 && tick) ? m_pend[k] : m_dir[k];
    vld = 1; r = 0;
    if (m_s2[5]) r = 0;
    else if (m_s2[4]) r = 1;
    else if (m_s2[3]) r = 2;
    else if (m_s2[2]) r = 3;
    else vld = 0;
    if (m_st[k] == 0) m_cnt[k] = 0;
    else if (en) m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
    m_dir[k] = dnext;
    if (vld && r != opposite(dnext)) m_pend[k] = r;
    case (m_st[k])
      0: if (start) m_st[k] = 1;
      1: if (tick) begin
        dc = (dnext == 3) ? 1 : (dnext == 2) ? -1 : 0;
        dr = (dnext == 1) ? 1 : (dnext == 0) ? -1 : 0;
        nc = m_col[k][0] + dc;
        nr = m_row[k][0] + dr;
        off = (nc < 0) || (nc > 63) || (nr < 0) || (nr > 47);
        if (off && !wrapm) begin
          m_st[k] = 2;
          m_go[k] = 1;
        end else begin
          for (int i = 3; i > 0; i--) begin
            m_col[k][i] = m_col[k][i-1];
            m_row[k][i] = m_row[k][i-1];
          end
          m_col[k][0] = (nc + 64) % 64;
          m_row[k][0] = (nr + 48) % 48;
        end
      end
      default: if (tick) begin
        if (m_blink[k] == BC - 1) begin
          m_st[k] = 0; m_bo[k] = 0; m_go[k] = 0; m_blink[k] = 0;
          m_load(k);
        end else begin
          m_bo[k] = !m_bo[k];
          m_blink[k]++;
        end
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_cnt[k] = 0; m_blink[k] = 0; m_bo[k] = 0; m_go[k] = 0;
        m_load(k);
      end
      m_s1 = '0; m_s2 = '0; m_cprev = 0;
    end else begin
      m_step(0, 1'b1);
      m_step(1, 1'b0);
      m_cprev = m_s2[1];
      m_s2 = m_s1;
      m_s1 = {btnU, btnD, btnL, btnR, btnC, pause};
    end
  end

  function automatic logic [81:0] model_vec(input int k);
    logic [81:0] v;
    for (int i = 0; i < 4; i++) begin
      v[81 - 10*i -: 10] = 10'(m_col[k][i] * 10 + 5);
      v[41 - 10*i -: 10] = 10'(m_row[k][i] * 10 + 5);
    end
    v[1] = m_bo[k];
    v[0] = m_go[k];
    return v;
  endfunction

  function automatic logic [81:0] dut_vec(input int k);
    logic [81:0] v;
    for (int i = 0; i < 4; i++) begin
      v[81 - 10*i -: 10] = xw[k][i];
      v[41 - 10*i -: 10] = yw[k][i];
    end
    v[1] = bo_w[k];
    v[0] = go_w[k];
    return v;
  endfunction

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    chk("model_wrap",   dut_vec(0), model_vec(0));
    chk("model_nowrap", dut_vec(1), model_vec(1));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_move(input int k, output int cyc);
    logic [19:0] h0;
    h0  = {xw[k][0], yw[k][0]};
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ({xw[k][0], yw[k][0]} != h0) begin
        cyc = c;
        break;
      end
    end
    n_tests++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL wait_move inst %0d: head unchanged after 40 cycles, required a move", k);
    end
  endtask

  initial begin
    int cyc, toggles, last, moves;
    logic prev_bo;
    logic [19:0] h0;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle at start position
    repeat (20) @(negedge clk);
    chk("t1_x1", xw[1][0], 10'd45);
    chk("t1_x4", xw[1][3], 10'd15);
    chk("t1_y1", yw[1][0], 10'd105);
    chk("t1_bo", bo_w[1], 1'b0);
    chk("t1_go", go_w[1], 1'b0);

    // 2: start, first move after sync + edge detect + 4 counted cycles
    btnC = 1'b1;
    @(negedge clk);
    btnC = 1'b0;
    wait_move(0, cyc);
    chk("t2_latency", cyc, 6);
    chk("t2_x1", xw[0][0], 10'd55);
    chk("t2_x2", xw[0][1], 10'd45);
    chk("t2_x4", xw[0][3], 10'd25);
    chk("t2_y4", yw[0][3], 10'd105);

    // 3: reverse request ignored, then turn up
    btnL = 1'b1;
    wait_move(0, cyc);
    wait_move(0, cyc);
    btnL = 1'b0;
    chk("t3_left_ignored_x1", xw[0][0], 10'd75);
    chk("t3_left_ignored_y1", yw[0][0], 10'd105);
    btnU = 1'b1;
    wait_move(0, cyc);
    chk("t3_up_y1", yw[0][0], 10'd95);
    chk("t3_up_x1", xw[0][0], 10'd75);
    chk("t3_up_y2", yw[0][1], 10'd105);

    // 4: run right to the edge: wrap vs game over
    btnU = 1'b0;
    btnR = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (xw[0][0] == 10'd635) break;
      wait_move(0, cyc);
    end
    btnR = 1'b0;
    chk("t4_at_edge", xw[0][0], 10'd635);
    wait_move(0, cyc);
    chk("t4_wrap_x1", xw[0][0], 10'd5);
    chk("t4_wrap_y1", yw[0][0], 10'd95);
    chk("t4_nowrap_go", go_w[1], 1'b1);
    chk("t4_nowrap_frozen", xw[1][0], 10'd635);
    toggles = 0; last = 0; prev_bo = bo_w[1];
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bo_w[1] != prev_bo) begin
        toggles++;
        chk("t4_blink_period", c - last, 4);
        last = c;
        prev_bo = bo_w[1];
      end
      if (!go_w[1]) break;
    end
    chk("t4_toggles", toggles, BC);
    chk("t4_idle_go", go_w[1], 1'b0);
    chk("t4_idle_bo", bo_w[1], 1'b0);
    chk("t4_idle_x1", xw[1][0], 10'd45);
    chk("t4_idle_x4", xw[1][3], 10'd15);
    chk("t4_idle_y1", yw[1][0], 10'd105);

    // 5: pause with the counter reaching 2, release, move 2 counts later
    btnC = 1'b1;
    @(negedge clk);
    btnC = 1'b0;
    wait_move(0, cyc);
    pause = 1'b1;
    h0 = {xw[0][0], yw[0][0]};
    moves = 0;
    repeat (50) begin
      @(negedge clk);
      if ({xw[0][0], yw[0][0]} != h0) moves++;
    end
    chk("t5_paused_moves", moves, 0);
    pause = 1'b0;
    wait_move(0, cyc);
    chk("t5_release_latency", cyc, 4);

    // 6: drive the non-wrapping snake into the top wall, reset mid-blink
    btnU = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (go_w[1] && bo_w[1]) begin
        cyc = c;
        break;
      end
    end
    btnU = 1'b0;
    n_tests++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL t6_reach_blackout: blackout never high in OVER, required within 200 cycles");
    end
    #2 reset = 1'b1;
    #1;
    chk("t6_bo", bo_w[1], 1'b0);
    chk("t6_go", go_w[1], 1'b0);
    chk("t6_x1", xw[1][0], 10'd45);
    chk("t6_y1", yw[1][0], 10'd105);
    chk("t6_x4", xw[1][3], 10'd15);
    chk("t6_wrap_x1", xw[0][0], 10'd45);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_stays_idle_x1", xw[1][0], 10'd45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
